// File: rtl/autoconfig_pkg.sv
// Shared constants and types for the Zorro II AutoConfig chain engine.
// Register offsets are expressed in A[6:1] units (byte address / 2).
package autoconfig_pkg;

  localparam logic [5:0] ER_TYPE_HI = 6'h00;
  localparam logic [5:0] ER_TYPE_LO = 6'h01;
  localparam logic [5:0] PRODUCT_HI = 6'h02;
  localparam logic [5:0] PRODUCT_LO = 6'h03;
  localparam logic [5:0] FLAGS_HI   = 6'h04;
  localparam logic [5:0] FLAGS_LO   = 6'h05;
  localparam logic [5:0] MANUF_0    = 6'h08;
  localparam logic [5:0] MANUF_3    = 6'h0B;
  localparam logic [5:0] SERIAL_0   = 6'h0C;
  localparam logic [5:0] SERIAL_7   = 6'h13;
  localparam logic [5:0] ROMVEC_0   = 6'h14;
  localparam logic [5:0] ROMVEC_3   = 6'h17;
  localparam logic [5:0] BASE_HI    = 6'h24;
  localparam logic [5:0] BASE_LO    = 6'h25;
  localparam logic [5:0] SHUTUP     = 6'h26;

  localparam logic [2:0] SIZE_8M   = 3'b000;
  localparam logic [2:0] SIZE_64K  = 3'b001;
  localparam logic [2:0] SIZE_128K = 3'b010;
  localparam logic [2:0] SIZE_256K = 3'b011;
  localparam logic [2:0] SIZE_512K = 3'b100;
  localparam logic [2:0] SIZE_1M   = 3'b101;
  localparam logic [2:0] SIZE_2M   = 3'b110;
  localparam logic [2:0] SIZE_4M   = 3'b111;

  localparam logic [7:0] Z2_SPACE = 8'hE8;

  typedef struct packed {
    logic        memlist;
    logic        romvec_valid;
    logic [2:0]  size;
    logic [7:0]  product;
    logic [15:0] romvec;
  } board_cfg_t;

  // Nibble of a field read MSB first: the register at 'last' holds the LS nibble.
  function automatic logic [3:0] nibble_from_msb(input logic [31:0] word,
                                                 input logic [5:0]  last,
                                                 input logic [5:0]  a_low);
    return 4'(word >> {last - a_low, 2'b00});
  endfunction

endpackage

// File: rtl/autoconfig_rom_nibble.sv
// Combinational AutoConfig register file for one board: maps A[6:1] to the
// nibble presented on D[15:12], inverted everywhere except er_Type.
module autoconfig_rom_nibble
  import autoconfig_pkg::*;
(
  input  logic [5:0]  a_low,
  input  logic        chained,
  input  logic        memlist,
  input  logic        romvec_valid,
  input  logic [2:0]  size,
  input  logic [7:0]  product,
  input  logic [15:0] manuf,
  input  logic [31:0] serial,
  input  logic [15:0] romvec,
  output logic [3:0]  nibble
);

  logic [3:0] raw;
  logic       invert;

  always_comb begin
    raw    = 4'h0;
    invert = 1'b1;
    if (a_low == ER_TYPE_HI) begin
      raw    = {2'b11, memlist, romvec_valid};
      invert = 1'b0;
    end else if (a_low == ER_TYPE_LO) begin
      raw    = {chained, size};
      invert = 1'b0;
    end else if (a_low == PRODUCT_HI) begin
      raw = product[7:4];
    end else if (a_low == PRODUCT_LO) begin
      raw = product[3:0];
    end else if (a_low >= MANUF_0 && a_low <= MANUF_3) begin
      raw = nibble_from_msb({16'h0000, manuf}, MANUF_3, a_low);
    end else if (a_low >= SERIAL_0 && a_low <= SERIAL_7) begin
      raw = nibble_from_msb(serial, SERIAL_7, a_low);
    end else if (a_low >= ROMVEC_0 && a_low <= ROMVEC_3) begin
      raw = nibble_from_msb({16'h0000, romvec}, ROMVEC_3, a_low);
    end
  end

  assign nibble = invert ? ~raw : raw;

endmodule

// File: rtl/autoconfig_chain.sv
// Zorro II AutoConfig engine presenting up to NUM_BOARDS logical boards in
// sequence at $E80000, with runtime enable mask, dynamic chaining and shut-up.
module autoconfig_chain #(
  parameter int                      NUM_BOARDS   = 2,
  parameter logic [15:0]             MANUF_ID     = 16'h082C,
  parameter logic [8*NUM_BOARDS-1:0] PRODUCT_IDS  = {8'd11, 8'd10},
  parameter logic [3*NUM_BOARDS-1:0] SIZE_CODES   = {3'b001, 3'b111},
  parameter logic [NUM_BOARDS-1:0]   MEMLIST      = 2'b01,
  parameter logic [NUM_BOARDS-1:0]   ROMVEC_VALID = 2'b10,
  parameter logic [16*NUM_BOARDS-1:0] ROMVEC     = {16'h0000, 16'h0000},
  parameter logic [31:0]             SERIAL       = 32'h0000_0001
) (
  input  logic                    C7M,
  input  logic                    RESET,
  input  logic                    CFGIN_n,
  input  logic [NUM_BOARDS-1:0]   BOARD_EN,
  input  logic                    AS_n,
  input  logic                    DS_n,
  input  logic                    RW_n,
  input  logic [7:0]              A_HIGH,
  input  logic [5:0]              A_LOW,
  input  logic [3:0]              D_IN,
  output logic [3:0]              D_OUT,
  output logic                    D_OE,
  output logic [8*NUM_BOARDS-1:0] BASE,
  output logic [NUM_BOARDS-1:0]   CONFIGURED_n,
  output logic [NUM_BOARDS-1:0]   SHUTUP,
  output logic                    CFGOUT_n
);

  import autoconfig_pkg::*;

  localparam int IDX_W = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

  logic [1:0]                  as_sync, ds_sync, cfgin_sync;
  logic                        as_s, ds_s, cfgin_s;
  logic [NUM_BOARDS-1:0]       done, cfg_n_q, shut_q;
  logic [NUM_BOARDS-1:0][7:0]  base_q;
  logic [IDX_W-1:0]            act;
  logic                        any_active, chained;
  logic                        bus_hit, rd, wr, write_seen;
  logic [3:0]                  hold, d_out_q, nibble;
  logic                        d_oe_q, cfgout_q;
  board_cfg_t                  cur;

  // Stage 0: two-flop synchronisers for the asynchronous bus strobes and chain input
  always_ff @(posedge C7M) begin
    if (RESET) begin
      as_sync    <= 2'b11;
      ds_sync    <= 2'b11;
      cfgin_sync <= 2'b11;
    end else begin
      as_sync    <= {as_sync[0], AS_n};
      ds_sync    <= {ds_sync[0], DS_n};
      cfgin_sync <= {cfgin_sync[0], CFGIN_n};
    end
  end

  assign as_s    = as_sync[1];
  assign ds_s    = ds_sync[1];
  assign cfgin_s = cfgin_sync[1];

  assign done = ~cfg_n_q | shut_q | ~BOARD_EN;

  // Active board is the lowest not-done index; chained if any higher one remains.
  always_comb begin
    act        = '0;
    any_active = 1'b0;
    chained    = 1'b0;
    for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
      if (!done[i]) begin
        act        = IDX_W'(i);
        any_active = 1'b1;
      end
    end
    for (int i = 0; i < NUM_BOARDS; i++) begin
      if (!done[i] && IDX_W'(i) > act) chained = 1'b1;
    end
  end

  always_comb begin
    cur              = '0;
    cur.memlist      = MEMLIST[act];
    cur.romvec_valid = ROMVEC_VALID[act];
    cur.size         = SIZE_CODES[3*act +: 3];
    cur.product      = PRODUCT_IDS[8*act +: 8];
    cur.romvec       = ROMVEC[16*act +: 16];
  end

  autoconfig_rom_nibble u_rom (
    .a_low        (A_LOW),
    .chained      (chained),
    .memlist      (cur.memlist),
    .romvec_valid (cur.romvec_valid),
    .size         (cur.size),
    .product      (cur.product),
    .manuf        (MANUF_ID),
    .serial       (SERIAL),
    .romvec       (cur.romvec),
    .nibble       (nibble)
  );

  assign bus_hit = ~cfgin_s & any_active & (A_HIGH == Z2_SPACE);
  assign rd      = bus_hit & ~as_s & RW_n;
  assign wr      = bus_hit & ~as_s & ~ds_s & ~RW_n & ~write_seen;

  // Stage 1: registered read data, per-board configuration state and chain output
  always_ff @(posedge C7M) begin
    if (RESET) begin
      d_oe_q     <= 1'b0;
      d_out_q    <= 4'h0;
      cfgout_q   <= 1'b1;
      write_seen <= 1'b0;
      hold       <= 4'h0;
      cfg_n_q    <= '1;
      shut_q     <= '0;
      base_q     <= '0;
    end else begin
      cfgout_q <= any_active;
      d_oe_q   <= rd;
      if (rd) d_out_q <= nibble;
      if (as_s)    write_seen <= 1'b0;
      else if (wr) write_seen <= 1'b1;
      // write_seen also guards the next board after an advance inside one AS cycle
      if (wr) begin
        case (A_LOW)
          BASE_LO: hold <= D_IN;
          BASE_HI: begin
            base_q[act]  <= MEMLIST[act] ? {D_IN, 4'h0} : {D_IN, hold};
            cfg_n_q[act] <= 1'b0;
            hold         <= 4'h0;
          end
          autoconfig_pkg::SHUTUP: shut_q[act] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign D_OUT        = d_out_q;
  assign D_OE         = d_oe_q;
  assign BASE         = base_q;
  assign CONFIGURED_n = cfg_n_q;
  assign SHUTUP       = shut_q;
  assign CFGOUT_n     = cfgout_q;

endmodule

// File: tb/tb_autoconfig_chain.sv
// Self-checking bench for autoconfig_chain: directed literal checks plus a
// randomized bus stream compared against a transaction-level board model.
module tb_autoconfig_chain;

  logic       C7M = 1'b0;
  logic       RESET = 1'b1;
  logic       CFGIN_n = 1'b0;
  logic [1:0] BOARD_EN = 2'b11;
  logic       AS_n = 1'b1, DS_n = 1'b1, RW_n = 1'b1;
  logic [7:0] A_HIGH = 8'h00;
  logic [5:0] A_LOW = 6'h00;
  logic [3:0] D_IN = 4'h0;
  logic [3:0] D_OUT;
  logic       D_OE;
  logic [15:0] BASE;
  logic [1:0] CONFIGURED_n, SHUTUP;
  logic       CFGOUT_n;

  autoconfig_chain #(.NUM_BOARDS(2)) dut (
    .C7M(C7M), .RESET(RESET), .CFGIN_n(CFGIN_n), .BOARD_EN(BOARD_EN),
    .AS_n(AS_n), .DS_n(DS_n), .RW_n(RW_n), .A_HIGH(A_HIGH), .A_LOW(A_LOW),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .BASE(BASE),
    .CONFIGURED_n(CONFIGURED_n), .SHUTUP(SHUTUP), .CFGOUT_n(CFGOUT_n)
  );

  always #70 C7M = ~C7M;

  // Board description as the bench understands it (board 0 first).
  localparam logic [15:0] M_ID = 16'h082C;
  localparam logic [31:0] M_SER = 32'h0000_0001;
  logic [7:0]  m_prod [2] = '{8'd10, 8'd11};
  logic [2:0]  m_size [2] = '{3'b111, 3'b001};
  logic        m_mem  [2] = '{1'b1, 1'b0};
  logic        m_rv   [2] = '{1'b0, 1'b1};
  logic [15:0] m_romv [2] = '{16'h0000, 16'h0000};

  // Model state
  logic [1:0] m_cfg = 2'b00, m_shut = 2'b00;
  logic [7:0] m_base [2] = '{8'h00, 8'h00};
  logic [3:0] m_hold = 4'h0;
  bit         chk_en = 1'b0;
  int         n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_done(input int i);
    return m_cfg[i] || m_shut[i] || !BOARD_EN[i];
  endfunction

  function automatic int m_active();
    for (int i = 0; i < 2; i++) if (!m_done(i)) return i;
    return -1;
  endfunction

  // Build the board's config ROM as a table of nibbles and look one up.
  function automatic logic [3:0] m_nibble(input int b, input int byte_off);
    logic [3:0] rom [64];
    bit ch;
    int k;
    ch = 1'b0;
    for (int j = b + 1; j < 2; j++) if (!m_done(j)) ch = 1'b1;
    for (int j = 0; j < 64; j++) rom[j] = 4'h0;
    rom[0] = {2'b11, m_mem[b], m_rv[b]};
    rom[1] = {ch, m_size[b]};
    rom[2] = m_prod[b][7:4];
    rom[3] = m_prod[b][3:0];
    for (int j = 0; j < 4; j++) rom[8 + j]  = 4'(M_ID >> (12 - 4*j));
    for (int j = 0; j < 8; j++) rom[12 + j] = 4'(M_SER >> (28 - 4*j));
    for (int j = 0; j < 4; j++) rom[20 + j] = 4'(m_romv[b] >> (12 - 4*j));
    k = byte_off / 2;
    return (k < 2) ? rom[k] : ~rom[k];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge C7M);
    #2;
  endtask

  task automatic model_clear();
    m_cfg = 2'b00; m_shut = 2'b00; m_hold = 4'h0;
    m_base[0] = 8'h00; m_base[1] = 8'h00;
  endtask

  // Per-cycle comparison of the configuration outputs while the bus is idle.
  always @(negedge C7M) begin
    if (chk_en) begin
      logic [1:0]  exp_cfgn;
      logic [15:0] exp_base;
      exp_cfgn = ~m_cfg;
      exp_base = {m_base[1], m_base[0]};
      check("base", BASE, exp_base);
      check("configured_n", CONFIGURED_n, exp_cfgn);
      check("shutup", SHUTUP, m_shut);
      check("cfgout_n", CFGOUT_n, (m_active() >= 0) ? 1 : 0);
      check("d_oe_idle", D_OE, 0);
    end
  end

  task automatic do_reset(input logic [1:0] en);
    chk_en = 1'b0;
    RESET = 1'b1; AS_n = 1'b1; DS_n = 1'b1; RW_n = 1'b1; BOARD_EN = en;
    tick(3);
    RESET = 1'b0;
    model_clear();
    tick(3);
    chk_en = 1'b1;
  endtask

  task automatic bus_read(input logic [7:0] ah, input int off, output logic [3:0] nib, output bit seen);
    int  b;
    bit  dec;
    b   = m_active();
    dec = !CFGIN_n && ah == 8'hE8 && b >= 0;
    chk_en = 1'b0;
    A_HIGH = ah; A_LOW = 6'(off >> 1); RW_n = 1'b1; AS_n = 1'b0; DS_n = 1'b0;
    seen = 1'b0; nib = 4'h0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge C7M);
      if (D_OE === 1'b1) begin seen = 1'b1; nib = D_OUT; end
    end
    if (dec) begin
      check("rd_oe", seen, 1);
      if (seen) check("rd_data", nib, m_nibble(b, off));
    end else begin
      check("rd_no_decode", seen, 0);
    end
    @(posedge C7M); #2;
    AS_n = 1'b1; DS_n = 1'b1;
    tick(5);
    chk_en = 1'b1;
  endtask

  task automatic bus_write(input logic [7:0] ah, input int off, input logic [3:0] d, input int hold_cyc);
    int b;
    bit dec;
    b   = m_active();
    dec = !CFGIN_n && ah == 8'hE8 && b >= 0;
    chk_en = 1'b0;
    A_HIGH = ah; A_LOW = 6'(off >> 1); D_IN = d; RW_n = 1'b0; AS_n = 1'b0; DS_n = 1'b0;
    tick(hold_cyc);
    AS_n = 1'b1; DS_n = 1'b1; A_HIGH = 8'h00;
    tick(5);
    RW_n = 1'b1;
    if (dec) begin
      case (off)
        'h4A: m_hold = d;
        'h48: begin
          m_base[b] = m_mem[b] ? {d, 4'h0} : {d, m_hold};
          m_cfg[b]  = 1'b1;
          m_hold    = 4'h0;
        end
        'h4C: m_shut[b] = 1'b1;
        default: ;
      endcase
    end
    chk_en = 1'b1;
  endtask

  task automatic lit_read(input string name, input int off, input logic [3:0] exp);
    logic [3:0] n;
    bit s;
    bus_read(8'hE8, off, n, s);
    check(name, n, exp);
  endtask

  task automatic lit_absent(input string name, input int off);
    logic [3:0] n;
    bit s;
    bus_read(8'hE8, off, n, s);
    check(name, s, 0);
  endtask

  initial begin
    #(140 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] n;
    bit s;
    int r, off;

    // Reset state
    do_reset(2'b11);
    check("rst_configured_n", CONFIGURED_n, 2'b11);
    check("rst_cfgout_n", CFGOUT_n, 1);
    check("rst_d_oe", D_OE, 0);
    check("rst_base", BASE, 16'h0000);
    check("rst_shutup", SHUTUP, 2'b00);

    // Board 0 register file
    lit_read("b0_er_type_hi", 'h00, 4'hE);
    lit_read("b0_er_type_lo", 'h02, 4'hF);
    lit_read("b0_prod_hi", 'h04, 4'hF);
    lit_read("b0_prod_lo", 'h06, 4'h5);
    lit_read("b0_flags", 'h08, 4'hF);
    lit_read("b0_manuf0", 'h10, 4'hF);
    lit_read("b0_manuf1", 'h12, 4'h7);
    lit_read("b0_manuf3", 'h16, 4'h3);
    lit_read("b0_serial7", 'h26, 4'hE);
    lit_read("b0_unmapped", 'h40, 4'hF);

    // Configure board 0 (memory), then board 1 (I/O)
    bus_write(8'hE8, 'h48, 4'h2, 6);
    check("b0_base", BASE[7:0], 8'h20);
    check("b0_cfg_n", CONFIGURED_n, 2'b10);
    lit_read("b1_er_type_lo", 'h02, 4'h1);
    lit_read("b1_er_type_hi", 'h00, 4'hD);
    lit_read("b1_prod_lo", 'h06, 4'h4);
    bus_write(8'hE8, 'h4A, 4'h9, 6);
    bus_write(8'hE8, 'h48, 4'hE, 6);
    check("b1_base", BASE, 16'hE920);
    check("both_cfg_n", CONFIGURED_n, 2'b00);
    check("done_cfgout_n", CFGOUT_n, 0);
    lit_absent("done_no_decode", 'h00);
    bus_write(8'hE8, 'h4C, 4'h0, 6);
    check("done_shutup_ignored", SHUTUP, 2'b00);

    // Board 1 disabled by jumper
    do_reset(2'b01);
    bus_write(8'hE8, 'h48, 4'h3, 6);
    check("en01_base", BASE, 16'h0030);
    check("en01_cfgout_n", CFGOUT_n, 0);
    check("en01_cfg_n", CONFIGURED_n, 2'b10);
    lit_absent("en01_no_decode", 'h02);

    // Shut-up board 0 with one long AS cycle: board 1 must not be shut up too
    do_reset(2'b11);
    bus_write(8'hE8, 'h4C, 4'h0, 14);
    check("shut_shutup", SHUTUP, 2'b01);
    check("shut_base", BASE, 16'h0000);
    check("shut_cfg_n", CONFIGURED_n, 2'b11);
    check("shut_cfgout_n", CFGOUT_n, 1);
    lit_read("shut_b1_er_type_lo", 'h02, 4'h1);
    // Long configure of board 1 must not touch anything else either
    bus_write(8'hE8, 'h48, 4'h7, 14);
    check("long_cfg_base", BASE, 16'h7000);
    check("long_cfg_n", CONFIGURED_n, 2'b01);

    // RESET in the middle of a read
    do_reset(2'b11);
    chk_en = 1'b0;
    A_HIGH = 8'hE8; A_LOW = 6'h00; RW_n = 1'b1; AS_n = 1'b0; DS_n = 1'b0;
    s = 1'b0;
    for (int c = 0; c < 8 && !s; c++) begin
      @(negedge C7M);
      if (D_OE === 1'b1) s = 1'b1;
    end
    check("midrd_oe_before", s, 1);
    @(posedge C7M); #2;
    RESET = 1'b1;
    @(posedge C7M); #1;
    check("midrd_d_oe", D_OE, 0);
    check("midrd_cfg_n", CONFIGURED_n, 2'b11);
    check("midrd_cfgout_n", CFGOUT_n, 1);
    #1;
    RESET = 1'b0; AS_n = 1'b1; DS_n = 1'b1;
    model_clear();
    tick(4);
    chk_en = 1'b1;
    bus_write(8'hE8, 'h48, 4'h4, 6);
    bus_write(8'hE8, 'h4A, 4'h5, 6);
    bus_write(8'hE8, 'h48, 4'h6, 6);
    check("post_rst_base", BASE, 16'h6540);
    check("post_rst_cfgout_n", CFGOUT_n, 0);

    // Randomized stream against the model
    do_reset(2'b11);
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 38) begin
        off = $urandom_range(0, 63) * 2;
        bus_read(($urandom_range(0, 9) == 0) ? 8'hE9 : 8'hE8, off, n, s);
      end else if (r < 58) begin
        bus_write(($urandom_range(0, 9) == 0) ? 8'hE9 : 8'hE8, 'h4A, 4'($urandom), $urandom_range(5, 14));
      end else if (r < 72) begin
        bus_write(($urandom_range(0, 9) == 0) ? 8'hE9 : 8'hE8, 'h48, 4'($urandom), $urandom_range(5, 14));
      end else if (r < 77) begin
        bus_write(8'hE8, 'h4C, 4'($urandom), $urandom_range(5, 14));
      end else if (r < 83) begin
        chk_en = 1'b0;
        BOARD_EN = 2'($urandom);
        tick(3);
        chk_en = 1'b1;
      end else if (r < 88) begin
        CFGIN_n = ($urandom_range(0, 2) == 0);
        tick(4);
      end else if (r < 93) begin
        bus_write(8'hE8, $urandom_range(0, 63) * 2, 4'($urandom), 6);
      end
      if (m_active() < 0 && $urandom_range(0, 2) == 0) begin
        CFGIN_n = 1'b0;
        do_reset(2'($urandom_range(1, 3)));
      end
    end

    chk_en = 1'b0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
